// File: rtl/clk_gen_tune_ctrl.sv
// clk_gen_tune_ctrl: ring-oscillator delay-select calibration; optional lock monitor under CLK_GEN_TUNE_LOCK_MON_EN
module clk_gen_tune_ctrl #(
    parameter int NUM_SEL       = 8,
    parameter int SEL_W         = $clog2(NUM_SEL),
    parameter int SETTLE_CYCLES = 16,
    parameter int WINDOW_CYCLES = 256,
    parameter int CNT_W         = 16
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] target_i,
    input  logic             manual_en_i,
    input  logic [SEL_W-1:0] manual_sel_i,
    input  logic             osc_div_i,
    output logic [SEL_W-1:0] stage_sel_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             fail_o,
    output logic [CNT_W-1:0] meas_count_o,
    output logic             drift_o
);
`ifdef CLK_GEN_TUNE_LOCK_MON_EN
    localparam bit LOCK_MON = 1'b1;
`else
    localparam bit LOCK_MON = 1'b0;
`endif
    localparam int TMR_W = $clog2((SETTLE_CYCLES > WINDOW_CYCLES ? SETTLE_CYCLES : WINDOW_CYCLES) + 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [TMR_W-1:0] MON_EVAL    = TMR_W'(WINDOW_CYCLES);
    localparam logic [SEL_W-1:0] SEL_MAX     = SEL_W'(NUM_SEL - 1);

    typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, EVAL, DONE} state_t;

    state_t           state, state_nx;
    logic [SEL_W-1:0] sel, sel_nx;
    logic             busy, busy_nx, done, done_nx, fail, fail_nx, drift, drift_nx;
    logic [CNT_W-1:0] meas, meas_nx, cnt, cnt_nx, cnt_inc;
    logic [TMR_W-1:0] tmr, tmr_nx;
    logic             sync1, sync2, hist, toggle;

    // bring the oscillator toggle into clk_i domain and keep one cycle of history
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= osc_div_i;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign toggle  = sync2 ^ hist;
    assign cnt_inc = (toggle && cnt != '1) ? cnt + 1'b1 : cnt;

    // next-state and output logic; manual override dominates everything
    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        busy_nx  = busy;
        done_nx  = done;
        fail_nx  = fail;
        meas_nx  = meas;
        drift_nx = drift;
        tmr_nx   = tmr;
        cnt_nx   = cnt;
        if (manual_en_i) begin
            state_nx = IDLE;
            sel_nx   = manual_sel_i;
            busy_nx  = 1'b0;
            done_nx  = 1'b0;
            fail_nx  = 1'b0;
            drift_nx = 1'b0;
            tmr_nx   = '0;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_nx = SETTLE;
                        sel_nx   = '0;
                        busy_nx  = 1'b1;
                        done_nx  = 1'b0;
                        fail_nx  = 1'b0;
                        drift_nx = 1'b0;
                        tmr_nx   = '0;
                        cnt_nx   = '0;
                    end else if (LOCK_MON && state == DONE && !fail) begin
                        tmr_nx   = (tmr == MON_EVAL) ? '0 : tmr + 1'b1;
                        cnt_nx   = (tmr == MON_EVAL) ? '0 : cnt_inc;
                        meas_nx  = (tmr == MON_EVAL) ? cnt : meas;
                        drift_nx = drift | (tmr == MON_EVAL && cnt > target_i);
                    end
                end
                SETTLE: begin
                    tmr_nx   = (tmr == SETTLE_LAST) ? '0 : tmr + 1'b1;
                    cnt_nx   = '0;
                    state_nx = (tmr == SETTLE_LAST) ? MEASURE : SETTLE;
                end
                MEASURE: begin
                    tmr_nx   = (tmr == WIN_LAST) ? '0 : tmr + 1'b1;
                    cnt_nx   = cnt_inc;
                    state_nx = (tmr == WIN_LAST) ? EVAL : MEASURE;
                end
                EVAL: begin
                    meas_nx = cnt;
                    tmr_nx  = '0;
                    cnt_nx  = '0;
                    if (cnt <= target_i || sel == SEL_MAX) begin
                        state_nx = DONE;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                        fail_nx  = cnt > target_i;
                    end else begin
                        state_nx = SETTLE;
                        sel_nx   = sel + 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // controller state register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= IDLE;
            sel   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            fail  <= 1'b0;
            meas  <= '0;
            drift <= 1'b0;
            tmr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            sel   <= sel_nx;
            busy  <= busy_nx;
            done  <= done_nx;
            fail  <= fail_nx;
            meas  <= meas_nx;
            drift <= drift_nx;
            tmr   <= tmr_nx;
            cnt   <= cnt_nx;
        end
    end

    assign stage_sel_o  = sel;
    assign busy_o       = busy;
    assign done_o       = done;
    assign fail_o       = fail;
    assign meas_count_o = meas;
    assign drift_o      = LOCK_MON && drift;
endmodule

// File: tb/tb_clk_gen_tune_ctrl.sv
// tb_clk_gen_tune_ctrl: directed vector bench for clk_gen_tune_ctrl
module tb_clk_gen_tune_ctrl;
    logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, manual_en = 1'b0, osc = 1'b0;
    logic [15:0] target = '0;
    logic [2:0]  manual_sel = '0;
    logic [2:0]  sel;
    logic        busy, done, fail, drift;
    logic [15:0] meas;
    int tests = 0, fails = 0;
    int mode = 0, iv = 2, oc = 0;

    typedef struct {
        int target; int mode; int iv; int poke;
        int exp_sel; int exp_cnt; int exp_fail; int exp_lat;
    } vec_t;
    vec_t vecs[6];

    clk_gen_tune_ctrl dut (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(start), .target_i(target),
        .manual_en_i(manual_en), .manual_sel_i(manual_sel), .osc_div_i(osc),
        .stage_sel_o(sel), .busy_o(busy), .done_o(done), .fail_o(fail),
        .meas_count_o(meas), .drift_o(drift)
    );

    always #5 clk = ~clk;

    // oscillator model: toggles every iv cycles (mode 0) or every sel+2 cycles (mode 1); iv=0 holds still
    always @(posedge clk) begin
        int cur;
        #2;
        cur = (mode == 1) ? int'(sel) + 2 : iv;
        if (cur > 0) begin
            if (oc >= cur - 1) begin
                osc = ~osc;
                oc = 0;
            end else oc++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_near(input string name, input int act, input int exp);
        tests++;
        if (act > exp + 1 || act + 1 < exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d +-1", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_sel"}, 32'(sel), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_fail"}, 32'(fail), 0);
        chk({tag, "_meas"}, 32'(meas), 0);
        chk({tag, "_drift"}, 32'(drift), 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        string tag;
        tag = $sformatf("vec%0d", idx);
        target = 16'(v.target);
        mode = v.mode;
        iv = v.iv;
        @(negedge clk);
        start = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
            if (n == 1) begin
                start = 1'b0;
                chk({tag, "_busy_start"}, 32'(busy), 1);
                chk({tag, "_sel_start"}, 32'(sel), 0);
            end
            if (v.poke != 0 && n == v.poke) start = 1'b1;
            if (v.poke != 0 && n == v.poke + 1) start = 1'b0;
        end while (!done && n < 6000);
        chk({tag, "_latency"}, 32'(n), 32'(v.exp_lat));
        chk({tag, "_sel"}, 32'(sel), 32'(v.exp_sel));
        chk_near({tag, "_meas"}, int'(meas), v.exp_cnt);
        chk({tag, "_fail"}, 32'(fail), 32'(v.exp_fail));
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 1);
    endtask

    initial begin
        int n;
        logic [15:0] saved;
        vecs[0] = '{200, 0, 2, 0,   0, 128, 0, 274};
        vecs[1] = '{60,  1, 2, 0,   3, 51,  0, 1093};
        vecs[2] = '{10,  0, 2, 0,   7, 128, 1, 2185};
        vecs[3] = '{90,  1, 2, 0,   1, 85,  0, 547};
        vecs[4] = '{0,   0, 0, 0,   0, 0,   0, 274};
        vecs[5] = '{200, 0, 2, 100, 0, 128, 0, 274};

        target = 16'($urandom);
        manual_sel = 3'($urandom);
        manual_en = 1'($urandom);
        start = 1'($urandom);
        #23 rst_n = 1'b0;
        #1 chk_zero("reset_async");
        start = 1'b0;
        manual_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk_zero("reset_release");

        foreach (vecs[i]) run_vec(vecs[i], i);

        target = 16'd60;
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (sel != 3'd2 && n < 3000) begin
            @(posedge clk);
            #1 n++;
        end
        chk("ovr_reach_sel2", 32'(sel), 2);
        repeat (76) @(posedge clk);
        #1 saved = meas;
        chk_near("ovr_prev_meas", int'(saved), 85);
        @(negedge clk);
        manual_en = 1'b1;
        manual_sel = 3'd5;
        @(posedge clk);
        #1;
        chk("ovr_busy", 32'(busy), 0);
        chk("ovr_done", 32'(done), 0);
        chk("ovr_sel", 32'(sel), 5);
        chk("ovr_meas_kept", 32'(meas), 32'(saved));
        start = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("ovr_start_ignored_busy", 32'(busy), 0);
        chk("ovr_start_ignored_sel", 32'(sel), 5);
        manual_sel = 3'd3;
        @(posedge clk);
        #1 chk("ovr_sel_track", 32'(sel), 3);
        @(negedge clk);
        manual_en = 1'b0;
        start = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        chk("ovr_idle_busy", 32'(busy), 0);
        chk("ovr_idle_done", 32'(done), 0);
        chk("ovr_idle_sel", 32'(sel), 3);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (400) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("reset_mid");
        #10 rst_n = 1'b1;
        repeat (600) @(posedge clk);
        #1;
        chk("reset_mid_no_resume_busy", 32'(busy), 0);
        chk("reset_mid_no_resume_sel", 32'(sel), 0);
        chk("reset_mid_no_resume_done", 32'(done), 0);

        run_vec(vecs[0], 10);
        chk("mon_drift_initial", 32'(drift), 0);
        saved = meas;
        iv = 1;
`ifdef CLK_GEN_TUNE_LOCK_MON_EN
        n = 0;
        while (!drift && n < 2 * 257 + 10) begin
            @(posedge clk);
            #1 n++;
        end
        chk("mon_drift_set", 32'(drift), 1);
        chk("mon_sel_held", 32'(sel), 0);
        chk("mon_done_held", 32'(done), 1);
        chk("mon_meas_high", 32'(meas > 16'd200), 1);
`else
        repeat (600) @(posedge clk);
        #1;
        chk("nomon_drift", 32'(drift), 0);
        chk("nomon_meas_static", 32'(meas), 32'(saved));
        chk("nomon_done_held", 32'(done), 1);
        chk("nomon_sel_held", 32'(sel), 0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
